dmem_responder: RTL and testbench



---
 rtl/dmem_pkg.sv | 22 ++
 rtl/dmem_lane_ops.sv | 45 ++++
 rtl/dmem_responder.sv | 177 +++++++++++++++++
 tb/tb_dmem_responder.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types for the data-memory responder: access sizes, FSM states and
// the word geometry of the backing array.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_D = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    ACCESS,
    RMW,
    RESP
  } state_e;

  localparam int WORD_BYTES = 8;

endpackage

// File: rtl/dmem_lane_ops.sv
// Byte-lane helpers for a little-endian 64-bit word: load extraction with
// sign/zero extension, and sub-word store merging.
module dmem_lane_ops
  import dmem_pkg::*;
(
  input  logic [63:0] word_i,
  input  logic [63:0] wdata_i,
  input  logic [2:0]  offset_i,
  input  size_e       size_i,
  input  logic        uns_i,
  output logic [63:0] ld_data_o,
  output logic [63:0] st_word_o
);

  function automatic logic [63:0] load_extract(input logic [63:0] word, input logic [2:0] offset,
                                               input size_e size, input logic uns);
    logic [63:0] sh;
    sh = word >> {offset, 3'b000};
    case (size)
      SZ_B:    return {{56{~uns & sh[7]}},  sh[7:0]};
      SZ_H:    return {{48{~uns & sh[15]}}, sh[15:0]};
      SZ_W:    return {{32{~uns & sh[31]}}, sh[31:0]};
      default: return sh;
    endcase
  endfunction

  function automatic logic [63:0] store_merge(input logic [63:0] word, input logic [63:0] wdata,
                                              input logic [2:0] offset, input size_e size);
    logic [7:0]  bm;
    logic [63:0] m;
    case (size)
      SZ_B:    bm = 8'h01;
      SZ_H:    bm = 8'h03;
      SZ_W:    bm = 8'h0F;
      default: bm = 8'hFF;
    endcase
    bm = bm << offset;
    for (int i = 0; i < 8; i++) m[i*8 +: 8] = {8{bm[i]}};
    return (word & ~m) | ((wdata << {offset, 3'b000}) & m);
  endfunction

  assign ld_data_o = load_extract(word_i, offset_i, size_i, uns_i);
  assign st_word_o = store_merge(word_i, wdata_i, offset_i, size_i);

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: single-outstanding RV64 load/store with wait states,
// sub-word read-modify-write and error reporting. Optional DMEM_STATS_EN adds counters.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
`ifdef DMEM_STATS_EN
  ,
  output logic [31:0] ld_count,
  output logic [31:0] st_count,
  output logic [31:0] err_count
`endif
);

  localparam int          IW         = $clog2(DEPTH);
  localparam int          AW         = IW + 3;
  localparam logic [63:0] ADDR_LIMIT = 64'(DEPTH) * 64'(WORD_BYTES);
  localparam logic [3:0]  WAIT_LAST  = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  function automatic logic req_error(input logic [63:0] addr, input logic [1:0] size);
    logic mis;
    case (size)
      2'b00:   mis = 1'b0;
      2'b01:   mis = addr[0];
      2'b10:   mis = |addr[1:0];
      default: mis = |addr[2:0];
    endcase
    return mis | (addr >= ADDR_LIMIT);
  endfunction

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic        err_q, req_ready_q, rsp_valid_q, rsp_err_q, busy_q;
  logic [63:0] rsp_rdata_q;
  logic        we_q, uns_q;
  size_e       size_q;
  logic [AW-1:0] addr_q;
  logic [63:0] wdata_q, merge_q;
  logic [63:0] mem [DEPTH];

  logic [IW-1:0] word_idx;
  logic [63:0]   mem_rd, lane_word, ld_data, merged;
  logic          mem_we, acc_err;

  assign acc_err   = req_error(req_addr, req_size);
  assign word_idx  = addr_q[AW-1:3];
  assign mem_rd    = mem[word_idx];
  assign lane_word = (state_q == RMW) ? merge_q : mem_rd;
  // Only whole-word writes: sd straight from ACCESS, sub-word stores from RMW.
  assign mem_we    = !err_q && ((state_q == ACCESS && we_q && size_q == SZ_D) || state_q == RMW);

  dmem_lane_ops u_lane (
    .word_i    (lane_word),
    .wdata_i   (wdata_q),
    .offset_i  (addr_q[2:0]),
    .size_i    (size_q),
    .uns_i     (uns_q),
    .ld_data_o (ld_data),
    .st_word_o (merged)
  );

  always_ff @(posedge clk) begin
    if (mem_we) mem[word_idx] <= merged;
  end

  always_ff @(posedge clk) begin
    if (state_q == IDLE && req_valid) begin
      we_q    <= req_we;
      uns_q   <= req_unsigned;
      size_q  <= size_e'(req_size);
      addr_q  <= req_addr[AW-1:0];
      wdata_q <= req_wdata;
    end
    if (state_q == ACCESS) merge_q <= mem_rd;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      err_q       <= 1'b0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 64'd0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (req_valid) begin
          req_ready_q <= 1'b0;
          busy_q      <= 1'b1;
          err_q       <= acc_err;
          cnt_q       <= 4'd0;
          // Errors skip the wait states and respond from ACCESS one edge later.
          state_q     <= (acc_err || WAIT_CYCLES == 0) ? ACCESS : WAIT;
        end
        WAIT: if (cnt_q == WAIT_LAST) begin
          cnt_q   <= 4'd0;
          state_q <= ACCESS;
        end else begin
          cnt_q <= cnt_q + 4'd1;
        end
        ACCESS: if (err_q || !we_q || size_q == SZ_D) begin
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= err_q;
          rsp_rdata_q <= (err_q || we_q) ? 64'd0 : ld_data;
          state_q     <= RESP;
        end else begin
          state_q <= RMW;
        end
        RMW: begin
          rsp_valid_q <= 1'b1;
          rsp_rdata_q <= 64'd0;
          state_q     <= RESP;
        end
        RESP: if (rsp_ready) begin
          rsp_valid_q <= 1'b0;
          rsp_rdata_q <= 64'd0;
          rsp_err_q   <= 1'b0;
          req_ready_q <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = busy_q;

`ifdef DMEM_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic [31:0] ld_cnt_q, st_cnt_q, err_cnt_q;
  logic        hs;
  assign hs = (state_q == RESP) && rsp_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_cnt_q  <= 32'd0;
      st_cnt_q  <= 32'd0;
      err_cnt_q <= 32'd0;
    end else if (hs) begin
      if (err_q)     err_cnt_q <= sat_inc(err_cnt_q);
      else if (we_q) st_cnt_q  <= sat_inc(st_cnt_q);
      else           ld_cnt_q  <= sat_inc(ld_cnt_q);
    end
  end

  assign ld_count  = ld_cnt_q;
  assign st_count  = st_cnt_q;
  assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a WAIT_CYCLES=2 instance and a WAIT_CYCLES=0
// instance share one request/response bus and are checked side by side.
module tb_dmem_responder;

  logic        clk, rst;
  logic        req_valid, req_we, req_unsigned, rsp_ready;
  logic [63:0] req_addr, req_wdata;
  logic [1:0]  req_size;

  logic        req_ready, rsp_valid, rsp_err, busy;
  logic [63:0] rsp_rdata;
  logic        z_req_ready, z_rsp_valid, z_rsp_err, z_busy;
  logic [63:0] z_rsp_rdata;
`ifdef DMEM_STATS_EN
  logic [31:0] ld_count, st_count, err_count;
  logic [31:0] z_ld_count, z_st_count, z_err_count;
`endif

  int n_chk  = 0;
  int n_fail = 0;
  int m_ld = 0, m_st = 0, m_err = 0;

  dmem_responder #(.DEPTH(256), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size), .req_unsigned(req_unsigned),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .busy(busy)
`ifdef DMEM_STATS_EN
    , .ld_count(ld_count), .st_count(st_count), .err_count(err_count)
`endif
  );

  dmem_responder #(.DEPTH(256), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(z_req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size), .req_unsigned(req_unsigned),
    .rsp_valid(z_rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err),
    .busy(z_busy)
`ifdef DMEM_STATS_EN
    , .ld_count(z_ld_count), .st_count(z_st_count), .err_count(z_err_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Edges from the accept edge until rsp_valid is seen on each instance.
  task automatic wait_rsp(output int lat, output int zlat);
    lat  = 0;
    zlat = 0;
    while (!rsp_valid && lat < 40) begin
      step();
      lat++;
      if (zlat == 0 && z_rsp_valid) zlat = lat;
    end
  endtask

  task automatic xact(input string tag, input logic we, input logic [1:0] size, input logic uns,
                      input logic [63:0] addr, input logic [63:0] wdata,
                      input int exp_lat, input logic exp_err, input logic [63:0] exp_data);
    int lat, zlat;
    chk({tag, " req_ready"}, 64'(req_ready), 64'd1);
    chk({tag, " z_req_ready"}, 64'(z_req_ready), 64'd1);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    step();
    req_valid = 1'b0;
    chk({tag, " busy"}, 64'(busy), 64'd1);
    wait_rsp(lat, zlat);
    chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, " z_latency"}, 64'(zlat), 64'(exp_err ? 1 : exp_lat - 2));
    chk({tag, " rdata"}, rsp_rdata, exp_data);
    chk({tag, " err"}, 64'(rsp_err), 64'(exp_err));
    chk({tag, " z_rdata"}, z_rsp_rdata, exp_data);
    chk({tag, " z_err"}, 64'(z_rsp_err), 64'(exp_err));
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk({tag, " rsp_valid_drop"}, 64'(rsp_valid), 64'd0);
    chk({tag, " busy_drop"}, 64'(busy), 64'd0);
    if (exp_err) m_err++;
    else if (we) m_st++;
    else m_ld++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, zlat;
    logic [63:0] held;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 64'd0; req_wdata = 64'd0;
    req_size = 2'b00; req_unsigned = 1'b0; rsp_ready = 1'b0;
    step(); step();
    chk("reset req_ready", 64'(req_ready), 64'd1);
    chk("reset rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset rdata", rsp_rdata, 64'd0);
    chk("reset err", 64'(rsp_err), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    rst = 1'b0;
    step();

    // we, size, uns, addr, wdata, latency(W=2), err, rdata
    xact("sd 0x10",  1, 2'b11, 0, 64'h10, 64'h1122334455667788, 3, 0, 64'd0);
    xact("ld 0x10",  0, 2'b11, 0, 64'h10, 64'd0, 3, 0, 64'h1122334455667788);
    xact("sb 0x13",  1, 2'b00, 0, 64'h13, 64'hAB, 4, 0, 64'd0);
    xact("lb 0x13",  0, 2'b00, 0, 64'h13, 64'd0, 3, 0, 64'hFFFFFFFFFFFFFFAB);
    xact("lbu 0x13", 0, 2'b00, 1, 64'h13, 64'd0, 3, 0, 64'h00000000000000AB);
    xact("ld merged", 0, 2'b11, 0, 64'h10, 64'd0, 3, 0, 64'h11223344AB667788);
    xact("sh 0x16",  1, 2'b01, 0, 64'h16, 64'h1234BEEF, 4, 0, 64'd0);
    xact("sw 0x10",  1, 2'b10, 0, 64'h10, 64'h55AACAFEF00D, 4, 0, 64'd0);
    xact("ld after sh/sw", 0, 2'b11, 0, 64'h10, 64'd0, 3, 0, 64'hBEEF3344CAFEF00D);
    xact("lh 0x16",  0, 2'b01, 0, 64'h16, 64'd0, 3, 0, 64'hFFFFFFFFFFFFBEEF);
    xact("lhu 0x10", 0, 2'b01, 1, 64'h10, 64'd0, 3, 0, 64'h000000000000F00D);
    xact("lh 0x12",  0, 2'b01, 0, 64'h12, 64'd0, 3, 0, 64'hFFFFFFFFFFFFCAFE);
    xact("lw 0x14",  0, 2'b10, 0, 64'h14, 64'd0, 3, 0, 64'hFFFFFFFFBEEF3344);
    xact("lwu 0x14", 0, 2'b10, 1, 64'h14, 64'd0, 3, 0, 64'h00000000BEEF3344);
    xact("lb 0x11",  0, 2'b00, 0, 64'h11, 64'd0, 3, 0, 64'hFFFFFFFFFFFFFFF0);
    xact("sd last",  1, 2'b11, 0, 64'h7F8, 64'hA5A50000FFFF1234, 3, 0, 64'd0);
    xact("ld last",  0, 2'b11, 0, 64'h7F8, 64'd0, 3, 0, 64'hA5A50000FFFF1234);

    xact("lw misaligned", 0, 2'b10, 0, 64'h16, 64'd0, 1, 1, 64'd0);
    xact("sh out of range", 1, 2'b01, 0, 64'h800, 64'hFFFF, 1, 1, 64'd0);
    xact("sw misaligned", 1, 2'b10, 0, 64'h12, 64'hFFFFFFFF, 1, 1, 64'd0);
    xact("ld far range", 0, 2'b11, 0, 64'h8000000000000010, 64'd0, 1, 1, 64'd0);
    xact("ld after errs", 0, 2'b11, 0, 64'h10, 64'd0, 3, 0, 64'hBEEF3344CAFEF00D);

    // Response back-pressure with a second request waiting on the bus.
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b11; req_unsigned = 1'b0; req_addr = 64'h10;
    step();
    req_addr = 64'h7F8;
    wait_rsp(lat, zlat);
    chk("bp latency", 64'(lat), 64'd3);
    held = rsp_rdata;
    chk("bp rdata", held, 64'hBEEF3344CAFEF00D);
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("bp hold%0d rsp_valid", i), 64'(rsp_valid), 64'd1);
      chk($sformatf("bp hold%0d rdata", i), rsp_rdata, held);
      chk($sformatf("bp hold%0d req_ready", i), 64'(req_ready), 64'd0);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("bp idle req_ready", 64'(req_ready), 64'd1);
    chk("bp idle rsp_valid", 64'(rsp_valid), 64'd0);
    step();
    req_valid = 1'b0;
    chk("bp second accepted", 64'(busy), 64'd1);
    wait_rsp(lat, zlat);
    chk("bp second latency", 64'(lat), 64'd3);
    chk("bp second rdata", rsp_rdata, 64'hA5A50000FFFF1234);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    m_ld += 2;

    // Reset while the W=2 instance sits in WAIT with a store pending.
    xact("sd 0x20", 1, 2'b11, 0, 64'h20, 64'h0123456789ABCDEF, 3, 0, 64'd0);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b11; req_addr = 64'h20;
    req_wdata = 64'hDEADBEEFDEADBEEF;
    step();
    req_valid = 1'b0;
    chk("abort busy before rst", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    chk("abort req_ready", 64'(req_ready), 64'd1);
    chk("abort busy", 64'(busy), 64'd0);
    chk("abort rsp_valid", 64'(rsp_valid), 64'd0);
    chk("abort z_busy", 64'(z_busy), 64'd0);
    m_ld = 0; m_st = 0; m_err = 0;
    step();
    rst = 1'b0;
    step();
    xact("ld 0x20 after abort", 0, 2'b11, 0, 64'h20, 64'd0, 3, 0, 64'h0123456789ABCDEF);
    xact("lw 0x8 store", 1, 2'b11, 0, 64'h8, 64'h0000000080000001, 3, 0, 64'd0);
    xact("lw 0x8", 0, 2'b10, 0, 64'h8, 64'd0, 3, 0, 64'hFFFFFFFF80000001);
    xact("lbu 0x20", 0, 2'b00, 1, 64'h20, 64'd0, 3, 0, 64'h00000000000000EF);
    xact("sb 0x21", 1, 2'b00, 0, 64'h21, 64'h77, 4, 0, 64'd0);
    xact("ld misaligned", 0, 2'b11, 0, 64'h24, 64'd0, 1, 1, 64'd0);

`ifdef DMEM_STATS_EN
    chk("ld_count", 64'(ld_count), 64'(m_ld));
    chk("st_count", 64'(st_count), 64'(m_st));
    chk("err_count", 64'(err_count), 64'(m_err));
    chk("z_ld_count", 64'(z_ld_count), 64'(m_ld));
    chk("z_st_count", 64'(z_st_count), 64'(m_st));
    chk("z_err_count", 64'(z_err_count), 64'(m_err));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
